// File: rtl/tx_packet_serializer.sv
// tx_packet_serializer
//   Serialises a 64-bit payload onto an RS-232 style line as a sequence of
//   8N1 bytes. The first byte is HEADER_BYTE. The 8 payload bytes follow,
//   least significant byte first.
//
//   Optional feature macro: TX_CHECKSUM_EN
//     When defined, a 10th byte is appended. It is the XOR of the 8 payload bytes.
//     When undefined, frames are 9 bytes and no checksum logic exists.
//
//   Parameters
//     CLKS_PER_BIT   clk cycles per serial bit (>= 2)
//     HEADER_BYTE    first byte of every frame
//     IDLE_GAP_BITS  mark bit-times inserted between bytes (0 = none)
//
//   Ports
//     clk       in   system clock, posedge
//     rst_n     in   asynchronous active-low reset
//     data_in   in   [63:0] payload, sampled only when tx_start is accepted
//     tx_start  in   one-cycle send request
//     tx_out    out  serial line, idle high, driven from a flop
//     busy      out  high from the cycle after acceptance through the last stop bit
//     done      out  one-cycle pulse when the frame is fully on the line
//
//   Handshake: a request is accepted on any clk edge where tx_start=1 and
//   busy=0. While busy=1, tx_start is ignored and is not queued. busy falls
//   in the same edge that raises done. A request presented in the done cycle
//   is therefore accepted.
module tx_packet_serializer #(
  parameter int          CLKS_PER_BIT  = 44,
  parameter logic [7:0]  HEADER_BYTE   = 8'h02,
  parameter int          IDLE_GAP_BITS = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] data_in,
  input  logic        tx_start,
  output logic        tx_out,
  output logic        busy,
  output logic        done
);

`ifdef TX_CHECKSUM_EN
  localparam int NBYTES = 10;
`else
  localparam int NBYTES = 9;
`endif
  localparam int BUF_W  = NBYTES * 8;
  localparam int BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;
  localparam logic [2:0] ST_GAP   = 3'd4;

  logic [2:0]        state;
  logic [BAUD_W-1:0] baud_cnt;
  logic [2:0]        bit_cnt;
  logic [15:0]       gap_cnt;
  logic [3:0]        byte_cnt;
  logic [BUF_W-1:0]  shift_reg;
  logic [BUF_W-1:0]  load_word;
  logic              baud_last;
  logic              last_byte;

  assign baud_last = (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));
  assign last_byte = (byte_cnt == 4'(NBYTES - 1));

`ifdef TX_CHECKSUM_EN
  logic [7:0] csum;
  always_comb begin
    csum = 8'h00;
    for (int k = 0; k < 8; k++) csum = csum ^ data_in[8*k +: 8];
  end
  assign load_word = {csum, data_in, HEADER_BYTE};
`else
  assign load_word = {data_in, HEADER_BYTE};
`endif

  // The shift register drops one bit per data bit. After the 8 data bits of
  // a byte, the next byte is already in the low 8 bits. tx_out is always
  // loaded with the level for the cycle that follows, so the line is a
  // clean flop output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      tx_out    <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
      byte_cnt  <= '0;
      shift_reg <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          tx_out <= 1'b1;
          if (tx_start) begin
            shift_reg <= load_word;
            state     <= ST_START;
            busy      <= 1'b1;
            tx_out    <= 1'b0;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            byte_cnt  <= '0;
          end
        end
        ST_START: begin
          if (baud_last) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            state    <= ST_DATA;
            tx_out   <= shift_reg[0];
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (baud_last) begin
            baud_cnt  <= '0;
            shift_reg <= shift_reg >> 1;
            if (bit_cnt == 3'd7) begin
              state  <= ST_STOP;
              tx_out <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              tx_out  <= shift_reg[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (baud_last) begin
            baud_cnt <= '0;
            if (last_byte) begin
              state    <= ST_IDLE;
              busy     <= 1'b0;
              done     <= 1'b1;
              tx_out   <= 1'b1;
              byte_cnt <= '0;
            end else begin
              byte_cnt <= byte_cnt + 1'b1;
              if (IDLE_GAP_BITS == 0) begin
                state  <= ST_START;
                tx_out <= 1'b0;
              end else begin
                state   <= ST_GAP;
                gap_cnt <= '0;
              end
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        ST_GAP: begin
          if (baud_last) begin
            baud_cnt <= '0;
            if (gap_cnt == 16'(IDLE_GAP_BITS - 1)) begin
              state  <= ST_START;
              tx_out <= 1'b0;
            end else begin
              gap_cnt <= gap_cnt + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          state  <= ST_IDLE;
          busy   <= 1'b0;
          tx_out <= 1'b1;
        end
      endcase
    end
  end

endmodule
